// File: rtl/sll_traverser.sv
// sll_traverser: walks a singly_linked_list from its head with Read_Addr ops,
// follows next pointers and streams each node's data on a valid/ready port in
// list order. Build option SLL_TRAV_TIMEOUT_EN adds a bounded wait for
// ll_op_done; without it WAIT blocks indefinitely and no counter exists.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for trav_start; snapshots head/length on accept
// S_ISSUE | raises ll_op_start with ll_addr = current pointer
// S_WAIT  | holds the op until ll_op_done; captures data and next pointer
// S_EMIT  | presents one beat; decides next read, normal end or error end
// S_FIN   | one-cycle trav_done pulse, drops busy, returns to idle
module sll_traverser #(
  parameter  int DATA_WIDTH     = 8,
  parameter  int MAX_NODE       = 8,
  parameter  int TIMEOUT_CYCLES = 16,
  localparam int ADDR_WIDTH     = $clog2(MAX_NODE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trav_start,
  output logic                  trav_busy,
  output logic                  trav_done,
  output logic                  trav_error,
  output logic [ADDR_WIDTH-1:0] trav_count,
  output logic [2:0]            ll_op,
  output logic [ADDR_WIDTH-1:0] ll_addr,
  output logic                  ll_op_start,
  input  logic                  ll_op_done,
  input  logic                  ll_fault,
  input  logic [DATA_WIDTH-1:0] ll_data_out,
  input  logic [ADDR_WIDTH-1:0] ll_next_node_addr,
  input  logic [ADDR_WIDTH-1:0] ll_head,
  input  logic [ADDR_WIDTH-1:0] ll_length,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_NULL = ADDR_WIDTH'(MAX_NODE + 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_CNT   = ADDR_WIDTH'(MAX_NODE);

  if (MAX_NODE < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("sll_traverser: MAX_NODE and TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_EMIT,
    S_FIN
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   ptr_q;
  logic [ADDR_WIDTH-1:0]   rem_q;
  logic [ADDR_WIDTH-1:0]   count_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    err_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    op_start_q;
  logic                    m_valid_q;
  logic [DATA_WIDTH-1:0]   m_data_q;
  logic                    m_last_q;
  logic [ADDR_WIDTH-1:0]   count_inc_d;
  logic [ADDR_WIDTH-1:0]   rem_dec_d;

`ifdef SLL_TRAV_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]        tmo_q;
`endif

  // Arithmetic helpers shared by the WAIT and EMIT decisions.
  assign count_inc_d = count_q + 1'b1;
  assign rem_dec_d   = rem_q - 1'b1;

  // Traversal FSM; every output is a register written here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= ADDR_NULL;
      rem_q      <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= ADDR_NULL;
      op_start_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
`ifdef SLL_TRAV_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (trav_start) begin
            ptr_q   <= ll_head;
            rem_q   <= ll_length;
            count_q <= '0;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            state_q <= (ll_length == '0) ? S_FIN : S_ISSUE;
          end
        end
        S_ISSUE: begin
          addr_q     <= ptr_q;
          op_start_q <= 1'b1;
`ifdef SLL_TRAV_TIMEOUT_EN
          tmo_q      <= TMO_W'(TIMEOUT_CYCLES - 1);
`endif
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          // The list latches read data only while the op is held, so the
          // request stays up until the completion is seen.
          if (ll_op_done) begin
            op_start_q <= 1'b0;
            if (ll_fault) begin
              err_q   <= 1'b1;
              state_q <= S_FIN;
            end else begin
              m_data_q  <= ll_data_out;
              m_valid_q <= 1'b1;
              m_last_q  <= (rem_q == ADDR_WIDTH'(1));
              ptr_q     <= ll_next_node_addr;
              rem_q     <= rem_dec_d;
              state_q   <= S_EMIT;
            end
          end
`ifdef SLL_TRAV_TIMEOUT_EN
          else if (tmo_q == '0) begin
            op_start_q <= 1'b0;
            err_q      <= 1'b1;
            state_q    <= S_FIN;
          end else begin
            tmo_q <= tmo_q - 1'b1;
          end
`endif
        end
        S_EMIT: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            count_q   <= count_inc_d;
            if (rem_q == '0) begin
              state_q <= S_FIN;
            end else if (ptr_q == ADDR_NULL || count_inc_d == MAX_CNT) begin
              // Null pointer before length is exhausted, or more nodes than
              // the list can hold: the list is broken or loops.
              err_q   <= 1'b1;
              state_q <= S_FIN;
            end else begin
              state_q <= S_ISSUE;
            end
          end
        end
        S_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign trav_busy   = busy_q;
  assign trav_done   = done_q;
  assign trav_error  = err_q;
  assign trav_count  = count_q;
  assign ll_op       = 3'd0;
  assign ll_addr     = addr_q;
  assign ll_op_start = op_start_q;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign m_last      = m_last_q;

endmodule

// File: tb/tb_sll_traverser.sv
// Bench for sll_traverser: a behavioural list stub answers reads two cycles
// after the request, a stream sink drives m_ready, and a reference walk of
// the stub memory predicts beats, addresses, count and error.
module tb_sll_traverser;

  localparam int AW      = 4;
  localparam int DW      = 8;
  localparam int MAXN    = 8;
  localparam int NULLA   = 9;
  localparam int STALL_N = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          trav_start = 1'b0;
  logic          trav_busy, trav_done, trav_error;
  logic [AW-1:0] trav_count;
  logic [2:0]    ll_op;
  logic [AW-1:0] ll_addr;
  logic          ll_op_start;
  logic          ll_op_done = 1'b0;
  logic          ll_fault = 1'b0;
  logic [DW-1:0] ll_data_out = '0;
  logic [AW-1:0] ll_next_node_addr = '0;
  logic [AW-1:0] ll_head = AW'(NULLA);
  logic [AW-1:0] ll_length = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last;

  sll_traverser dut (
    .clk(clk), .rst(rst), .trav_start(trav_start), .trav_busy(trav_busy),
    .trav_done(trav_done), .trav_error(trav_error), .trav_count(trav_count),
    .ll_op(ll_op), .ll_addr(ll_addr), .ll_op_start(ll_op_start),
    .ll_op_done(ll_op_done), .ll_fault(ll_fault), .ll_data_out(ll_data_out),
    .ll_next_node_addr(ll_next_node_addr), .ll_head(ll_head),
    .ll_length(ll_length), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  // stub memory and test controls (written by the initial block only)
  logic [DW-1:0] mem_d [16];
  logic [AW-1:0] mem_n [16];
  bit            stub_mute = 1'b0;
  bit            rnd_ready = 1'b0;
  int            fault_at  = -1;
  int            stall_at  = -1;

  // observations (written by the negedge process only)
  logic [DW-1:0] got_d [$];
  bit            got_l [$];
  int            got_a [$];
  int            rd_cnt = 0, beats = 0, stall_cyc = 0, lat_cnt = 0;
  int            stall_viol = 0, bad_op = 0, done_cnt = 0;
  bit            op_prev = 1'b0, stall_chk = 1'b0;
  logic [DW-1:0] sv_d = '0;
  bit            sv_l = 1'b0;

  // expectations
  logic [DW-1:0] exp_d [$];
  bit            exp_l [$];
  int            exp_a [$];
  bit            exp_err;
  int            exp_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // list stub, stream sink and monitors, all sampled away from the clock edge
  always @(negedge clk) begin
    ll_op_done = 1'b0;
    ll_fault   = 1'b0;
    if (ll_op_start && !op_prev) begin
      got_a.push_back(int'(ll_addr));
      if (ll_op != 3'd0) bad_op++;
    end
    op_prev = ll_op_start;
    if (!rst || !ll_op_start || stub_mute) begin
      lat_cnt = 0;
    end else begin
      lat_cnt++;
      if (lat_cnt == 2) begin
        ll_op_done        = 1'b1;
        ll_fault          = (rd_cnt == fault_at);
        ll_data_out       = mem_d[ll_addr];
        ll_next_node_addr = mem_n[ll_addr];
        rd_cnt++;
        lat_cnt = 0;
      end
    end

    if (stall_chk && (!m_valid || m_data !== sv_d || m_last !== sv_l)) stall_viol++;
    stall_chk = 1'b0;
    if (beats != stall_at) stall_cyc = 0;
    if (m_valid && beats == stall_at && stall_cyc < STALL_N) begin
      m_ready = 1'b0;
      stall_cyc++;
    end else begin
      m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (m_valid && m_ready) begin
      got_d.push_back(m_data);
      got_l.push_back(m_last);
      beats++;
    end else if (m_valid) begin
      stall_chk = 1'b1;
      sv_d      = m_data;
      sv_l      = m_last;
    end
    if (trav_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference walk: follow next pointers in the stub memory from head.
  task automatic model_walk(input int head, input int len, input int fault_k);
    int ptr, rem, cnt;
    exp_d.delete(); exp_l.delete(); exp_a.delete();
    exp_err = 1'b0;
    ptr = head; rem = len; cnt = 0;
    while (rem > 0) begin
      exp_a.push_back(ptr);
      if (cnt == fault_k) begin exp_err = 1'b1; break; end
      exp_d.push_back(mem_d[ptr]);
      rem--;
      exp_l.push_back(rem == 0);
      cnt++;
      ptr = int'(mem_n[ptr]);
      if (rem == 0) break;
      if (ptr == NULLA || cnt == MAXN) begin exp_err = 1'b1; break; end
    end
    exp_cnt = cnt;
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 16; a++) begin
      mem_d[a] = 8'($urandom);
      mem_n[a] = AW'(NULLA);
    end
  endtask

  task automatic set_three();
    clear_mem();
    mem_d[0] = 8'h11; mem_n[0] = 4'd1;
    mem_d[1] = 8'h22; mem_n[1] = 4'd2;
    mem_d[2] = 8'h33; mem_n[2] = AW'(NULLA);
  endtask

  task automatic build_list(input int n, input int extra, output int head, output int len);
    int perm [8];
    int j, t;
    for (int i = 0; i < 8; i++) perm[i] = i;
    for (int i = 7; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    clear_mem();
    for (int i = 0; i < n; i++) mem_n[perm[i]] = (i == n - 1) ? AW'(NULLA) : AW'(perm[i+1]);
    head = (n == 0) ? NULLA : perm[0];
    len  = (n + extra > 15) ? 15 : n + extra;
  endtask

  task automatic pulse_start();
    @(negedge clk) trav_start = 1'b1;
    @(negedge clk) trav_start = 1'b0;
  endtask

  task automatic wait_done(output bit seen, output int cyc);
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      seen = trav_done;
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk(tag, {trav_busy, trav_done, trav_error, ll_op_start, m_valid, m_last,
              m_data, trav_count, ll_addr, ll_op},
             {6'b0, 8'h00, 4'h0, 4'(NULLA), 3'd0});
  endtask

  task automatic run_walk(input string tag, input int head, input int len, input int fault_k,
                          input bit rnd, input int stall_k, input bit extra_start);
    int base_d, base_a, base_done, base_viol, base_bad, cyc, n;
    bit seen;
    model_walk(head, len, fault_k);
    base_d = got_d.size(); base_a = got_a.size(); base_done = done_cnt;
    base_viol = stall_viol; base_bad = bad_op;
    fault_at  = (fault_k < 0) ? -1 : rd_cnt + fault_k;
    stall_at  = (stall_k < 0) ? -1 : beats + stall_k;
    rnd_ready = rnd;
    ll_head   = AW'(head);
    ll_length = AW'(len);
    pulse_start();
    if (extra_start) begin
      repeat (2) @(negedge clk);
      trav_start = 1'b1;
      @(negedge clk) trav_start = 1'b0;
    end
    wait_done(seen, cyc);
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (len == 0) chk({tag, "_done_latency"}, cyc, 1);
    chk({tag, "_error"}, 32'(trav_error), 32'(exp_err));
    chk({tag, "_count"}, 32'(trav_count), exp_cnt);
    chk({tag, "_busy_low"}, 32'(trav_busy), 32'd0);
    repeat (2) @(negedge clk);
    chk({tag, "_done_pulses"}, done_cnt - base_done, 1);
    chk({tag, "_done_dropped"}, 32'(trav_done), 32'd0);
    chk({tag, "_error_held"}, 32'(trav_error), 32'(exp_err));
    chk({tag, "_nbeats"}, got_d.size() - base_d, exp_d.size());
    chk({tag, "_nreads"}, got_a.size() - base_a, exp_a.size());
    n = got_d.size() - base_d;
    for (int i = 0; i < exp_d.size() && i < n; i++) begin
      chk($sformatf("%s_data%0d", tag, i), 32'(got_d[base_d+i]), 32'(exp_d[i]));
      chk($sformatf("%s_last%0d", tag, i), 32'(got_l[base_d+i]), 32'(exp_l[i]));
    end
    n = got_a.size() - base_a;
    for (int i = 0; i < exp_a.size() && i < n; i++)
      chk($sformatf("%s_addr%0d", tag, i), got_a[base_a+i], exp_a[i]);
    chk({tag, "_stall_stable"}, stall_viol - base_viol, 0);
    chk({tag, "_op_code"}, bad_op - base_bad, 0);
  endtask

  initial begin
    int  head, len, n, extra, fk, cyc, base_done;
    bit  seen;

    clear_mem();
    repeat (3) @(posedge clk);
    #1 chk_idle_outs("reset_outs");
    @(negedge clk) rst = 1'b1;

    // three-node list, full rate, plus a start pulse while busy
    set_three();
    run_walk("t1_three", 0, 3, -1, 1'b0, -1, 1'b1);

    // empty list
    run_walk("t2_empty", NULLA, 0, -1, 1'b0, -1, 1'b0);

    // consumer stalls five cycles on the second beat
    set_three();
    run_walk("t3_stall", 0, 3, -1, 1'b0, 1, 1'b0);

    // list faults on the second read
    set_three();
    run_walk("t4_fault", 0, 3, 1, 1'b0, -1, 1'b0);

    // two-node loop with a length beyond capacity
    clear_mem();
    mem_d[0] = 8'hA0; mem_n[0] = 4'd1;
    mem_d[1] = 8'hB1; mem_n[1] = 4'd0;
    run_walk("t5_loop", 0, 15, -1, 1'b0, -1, 1'b0);

`ifdef SLL_TRAV_TIMEOUT_EN
    // list never completes the read
    set_three();
    stub_mute = 1'b1;
    ll_head = 4'd0; ll_length = 4'd3;
    pulse_start();
    wait_done(seen, cyc);
    chk("t5_tmo_done", 32'(seen), 32'd1);
    chk("t5_tmo_window", 32'(cyc >= 16 && cyc <= 20), 32'd1);
    chk("t5_tmo_error", 32'(trav_error), 32'd1);
    chk("t5_tmo_count", 32'(trav_count), 32'd0);
    chk("t5_tmo_op_low", 32'(ll_op_start), 32'd0);
    stub_mute = 1'b0;
    repeat (2) @(negedge clk);
`endif

    // reset while waiting on the list
    set_three();
    stub_mute = 1'b1;
    ll_head = 4'd0; ll_length = 4'd3;
    base_done = done_cnt;
    pulse_start();
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      seen = ll_op_start;
    end
    chk("t6_op_issued", 32'(seen), 32'd1);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk_idle_outs("t6_reset_outs");
    @(negedge clk) begin rst = 1'b1; stub_mute = 1'b0; end
    repeat (3) @(negedge clk);
    chk("t6_no_done", done_cnt - base_done, 0);
    set_three();
    run_walk("t6_after", 0, 3, -1, 1'b0, -1, 1'b0);

    // random lists, some broken, some faulting, random consumer backpressure
    for (int it = 0; it < 24; it++) begin
      n     = $urandom_range(0, 8);
      extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      build_list(n, extra, head, len);
      fk    = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 8) : -1;
      run_walk($sformatf("rnd%0d", it), head, len, fk, 1'b1, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
